// File: rtl/pixel_readout.sv
// Pixel array sequencer: erase/expose/convert phases, then per-pixel readout onto a valid/ready stream.
// Optional macro PIXEL_READOUT_GRAY_DECODE_EN converts captured gray code to binary before output.
module pixel_readout #(
  parameter int PIXEL_COUNT    = 4,
  parameter int COUNTER_WIDTH  = 8,
  parameter int ERASE_CYCLES   = 4,
  parameter int EXPOSE_CYCLES  = 16,
  parameter int CONVERT_CYCLES = 2**COUNTER_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             erase,
  output logic                             expose,
  output logic                             convert,
  output logic                             read,
  output logic [$clog2(PIXEL_COUNT)-1:0]   pixel_select,
  input  logic [COUNTER_WIDTH-1:0]         data,
  output logic [COUNTER_WIDTH-1:0]         pix_data,
  output logic [$clog2(PIXEL_COUNT)-1:0]   pix_index,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic                             pix_last,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int IW        = $clog2(PIXEL_COUNT);
  localparam int MAX_EX    = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAX_PHASE = (MAX_EX > CONVERT_CYCLES) ? MAX_EX : CONVERT_CYCLES;
  localparam int CW        = $clog2(MAX_PHASE) + 1;

  localparam logic [CW-1:0] ERASE_END   = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] EXPOSE_END  = CW'(EXPOSE_CYCLES - 1);
  localparam logic [CW-1:0] CONVERT_END = CW'(CONVERT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(PIXEL_COUNT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ERASE   = 4'd1,
    EXPOSE  = 4'd2,
    CONVERT = 4'd3,
    SEL     = 4'd4,
    WAIT    = 4'd5,
    SAMPLE  = 4'd6,
    HOLD    = 4'd7,
    DONE    = 4'd8
  } state_t;

  function automatic logic [COUNTER_WIDTH-1:0] gray_to_bin(input logic [COUNTER_WIDTH-1:0] g);
    logic [COUNTER_WIDTH-1:0] b;
    b = '0;
    b[COUNTER_WIDTH-1] = g[COUNTER_WIDTH-1];
    for (int i = COUNTER_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [COUNTER_WIDTH-1:0] pix_data_q, pix_data_d;
  logic [IW-1:0]            pix_index_q, pix_index_d;
  logic                     pix_last_q, pix_last_d;
  logic                     erase_q, expose_q, convert_q, read_q, valid_q, busy_q, done_q;
  logic                     erase_d, expose_d, convert_d, read_d, valid_d, busy_d, done_d;
  logic [COUNTER_WIDTH-1:0] capture_s;

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
  assign capture_s = gray_to_bin(data);
`else
  assign capture_s = data;
`endif

  // Next-state, phase counter, pixel index and sample capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pix_data_d  = pix_data_q;
    pix_index_d = pix_index_q;
    pix_last_d  = pix_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ERASE;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ERASE: begin
        if (cnt_q == ERASE_END) begin
          state_d = EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EXPOSE: begin
        if (cnt_q == EXPOSE_END) begin
          state_d = CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CONVERT: begin
        if (cnt_q == CONVERT_END) begin
          state_d = SEL;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEL:  state_d = WAIT;
      WAIT: state_d = SAMPLE;
      // Decoder output has settled two cycles after pixel_select moved
      SAMPLE: begin
        state_d     = HOLD;
        pix_data_d  = capture_s;
        pix_index_d = idx_q;
        pix_last_d  = (idx_q == LAST_IDX);
      end
      HOLD: begin
        if (pix_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = SEL;
            idx_d   = idx_q + IW'(1);
          end
        end else begin
          state_d = HOLD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the next state so the registered copies track the state register
  always_comb begin
    erase_d   = (state_d == ERASE);
    expose_d  = (state_d == EXPOSE);
    convert_d = (state_d == CONVERT);
    read_d    = (state_d == SEL) || (state_d == WAIT) || (state_d == SAMPLE) || (state_d == HOLD);
    valid_d   = (state_d == HOLD);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      pix_data_q  <= '0;
      pix_index_q <= '0;
      pix_last_q  <= 1'b0;
      erase_q     <= 1'b0;
      expose_q    <= 1'b0;
      convert_q   <= 1'b0;
      read_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pix_data_q  <= pix_data_d;
      pix_index_q <= pix_index_d;
      pix_last_q  <= pix_last_d;
      erase_q     <= erase_d;
      expose_q    <= expose_d;
      convert_q   <= convert_d;
      read_q      <= read_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign erase        = erase_q;
  assign expose       = expose_q;
  assign convert      = convert_q;
  assign read         = read_q;
  assign pixel_select = idx_q;
  assign pix_data     = pix_data_q;
  assign pix_index    = pix_index_q;
  assign pix_valid    = valid_q;
  assign pix_last     = pix_last_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 SHALL have parameter PIXEL_COUNT, default 4, meaning the number of pixels on the shared data bus (at least 2).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 8, meaning the width of the pixel data bus and of the sample.
REQ-003 SHALL have parameter ERASE_CYCLES, default 4, meaning the erase phase length in clk cycles (at least 1).
REQ-004 SHALL have parameter EXPOSE_CYCLES, default 16, meaning the expose phase length in clk cycles (at least 1).
REQ-005 SHALL have parameter CONVERT_CYCLES, default 2**COUNTER_WIDTH, meaning the convert phase length in clk cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: single-cycle frame request.
REQ-009 SHALL have port erase, expose, convert and read, outputs, 1 bit each: array phase controls.
REQ-010 SHALL have port pixel_select, output, $clog2(PIXEL_COUNT) bits: index of the pixel driving the bus.
REQ-011 SHALL have port data, input, COUNTER_WIDTH bits: gray-coded pixel value on the shared bus.
REQ-012 SHALL have port pix_data, output, COUNTER_WIDTH bits: sample value.
REQ-013 SHALL have port pix_index, output, $clog2(PIXEL_COUNT) bits: index of the pixel that produced the sample.
REQ-014 SHALL have port pix_valid, output, 1 bit, and pix_ready, input, 1 bit: stream handshake.
REQ-015 SHALL have port pix_last, output, 1 bit: high while the sample is for pixel PIXEL_COUNT-1.
REQ-016 SHALL have port busy, output, 1 bit, and frame_done, output, 1 bit: status; frame_done is a one-cycle pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ERASE, EXPOSE, CONVERT, SEL, WAIT, SAMPLE, HOLD and DONE.
REQ-018 SHALL move IDLE->ERASE on start=1; start SHALL be ignored in every other state.
REQ-019 SHALL hold erase=1 for exactly ERASE_CYCLES cycles, then expose=1 for EXPOSE_CYCLES cycles, then convert=1 for CONVERT_CYCLES cycles; at most one of the three is high at a time.
REQ-020 SHALL use one phase counter of width $clog2(max phase length)+1, cleared on every phase entry.
REQ-021 SHALL hold read=1 from SEL through the final HOLD, with no gaps between pixels.
REQ-022 SHALL set pixel_select to the pixel index in SEL.
REQ-023 SHALL enter WAIT one cycle after SEL and SAMPLE one cycle after WAIT, capturing data 2 cycles after each pixel_select change to cover the registered decoder.
REQ-024 SHALL drive pix_valid=1 in HOLD and hold pix_data, pix_index and pix_last stable until the cycle in which pix_valid and pix_ready are both high.
REQ-025 SHALL, on handshake in HOLD, go to SEL with index+1, or to DONE if the index was PIXEL_COUNT-1.
REQ-026 SHALL, with pix_ready held at 1, give a throughput of one sample per 4 cycles.
REQ-027 SHALL pulse frame_done for exactly 1 cycle in DONE, then return to IDLE.
REQ-028 SHALL drive busy=1 in every state except IDLE.
REQ-029 SHALL hold read=0 and pixel_select constant outside the read states.
REQ-030 SHALL hold the FSM in HOLD for any number of cycles while pix_ready=0, with no data re-capture.

Reset
REQ-031 SHALL, while reset=0, asynchronously force state IDLE, all counters 0, and erase, expose, convert, read, pix_valid, pix_last, busy and frame_done to 0.
REQ-032 SHALL, while reset=0, asynchronously force pixel_select, pix_index and pix_data to 0.
REQ-033 SHALL, on reset asserted mid-frame, abandon the frame without emitting frame_done; the first start after reset release begins a fresh frame.

Configuration
REQ-034 SHALL, with macro PIXEL_READOUT_GRAY_DECODE_EN defined, set pix_data to the binary value of the captured gray code: b[MSB]=g[MSB], b[i]=b[i+1] xor g[i], registered at SAMPLE.
REQ-035 SHALL, without macro PIXEL_READOUT_GRAY_DECODE_EN defined, pass the captured gray code to pix_data unchanged; all timing SHALL be identical in both builds.

Verification
REQ-036 SHALL test a pulse of start with ERASE_CYCLES=4, EXPOSE_CYCLES=16, CONVERT_CYCLES=256 -> erase high for 4 cycles, expose for 16 cycles, convert for 256 cycles, no overlap.
REQ-037 SHALL test, with the GRAY_DECODE_EN build, bus data 8'h80, 8'h03, 8'h00 and 8'h01 for pixels 0-3 -> pix_data 8'hFF, 8'h02, 8'h00 and 8'h01, with pix_last high only at index 3.
REQ-038 SHALL test pix_ready low for 10 cycles on pixel 1 -> pix_valid stays high with pix_data stable, read stays 1, and the pixel 2 SEL occurs only after the handshake.
REQ-039 SHALL test start pulsed during EXPOSE -> no effect, and exactly one frame_done at the end of the frame.
REQ-040 SHALL test reset=0 during WAIT of pixel 2 -> read, busy and pix_valid drop to 0 immediately, and no frame_done occurs.
REQ-041 SHALL test the build without the macro, with bus data 8'h80 -> pix_data 8'h80 at the same cycle position.
